// File: rtl/mii_mac_pkg.sv
// Shared constants and types for the MII transmit MAC.
//   - tx_state_t   : transmit FSM state encoding
//   - framing      : preamble/SFD, minimum frame, FCS and IFG sizes
//   - CRC-32       : reflected polynomial, init value and good-frame residue
package mii_mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GETPTR,
    ST_PRE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  localparam int unsigned LEN_W            = 11;
  localparam int unsigned PREAMBLE_NIBBLES = 15;
  localparam logic [3:0]  PREAMBLE_NIBBLE  = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE       = 4'hD;
  localparam int unsigned MIN_FRAME        = 60;
  localparam int unsigned FCS_BYTES        = 4;
  localparam int unsigned IFG_NIBBLES      = 24;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/mii_crc32_d8.sv
// Combinational CRC-32 (reflected) advance by one byte, LSB first.
//   crc_i  : current CRC register
//   data_i : byte to absorb
//   crc_o  : CRC register after the byte
module mii_crc32_d8
  import mii_mac_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_c;

  // Eight serial shift/xor steps unrolled into one cycle.
  always_comb begin
    crc_c = crc_i ^ {24'h000000, data_i};
    for (int i = 0; i < 8; i++) begin
      crc_c = crc_c[0] ? ((crc_c >> 1) ^ CRC_POLY) : (crc_c >> 1);
    end
    crc_o = crc_c;
  end

endmodule

// File: rtl/mii_mac_tx.sv
// MII transmit MAC: pops a descriptor, streams the frame bytes from the data
// FIFO onto the 4-bit MII bus as preamble/SFD, data, zero pad to 60 bytes,
// CRC-32 FCS, then holds off for the inter-frame gap.
//   clk, rst        : system clock (>= 4x tx_clk), async active-high reset
//   tx_clk          : PHY transmit clock, sampled as data
//   tx_dv, tx_d     : MII TX_EN / TXD
//   data_fifo_rd/din: byte read pulse / byte (valid 1 clk after the pulse)
//   ptr_fifo_rd/din : descriptor read pulse / descriptor ([10:0] = length)
//   ptr_fifo_empty  : descriptor FIFO empty
module mii_mac_tx
  import mii_mac_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_clk,
  output logic        tx_dv,
  output logic [3:0]  tx_d,
  output logic        data_fifo_rd,
  input  logic [7:0]  data_fifo_din,
  output logic        ptr_fifo_rd,
  input  logic [15:0] ptr_fifo_din,
  input  logic        ptr_fifo_empty
);

  logic [1:0]       sync_q;
  logic             tx_clk_prev_q;
  logic             nib_stb_c;

  tx_state_t        state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             hi_q, hi_d;
  logic [7:0]       byte_q, byte_d;
  logic [31:0]      crc_q, crc_d;
  logic             desc_wait_q, desc_wait_d;
  logic             rd_dly_q, rd_dly_d;
  logic             tx_dv_q, tx_dv_d;
  logic [3:0]       tx_d_q, tx_d_d;
  logic             ptr_rd_q, ptr_rd_d;
  logic             data_rd_q, data_rd_d;

  logic [31:0]      crc_next_c;
  logic [31:0]      fcs_c;
  logic [3:0]       fcs_nib_c;
  logic [LEN_W-1:0] cnt_inc_c;
  logic [4:0]       desc_rsvd_unused;

  assign desc_rsvd_unused = ptr_fifo_din[15:11];

  // tx_clk synchroniser and rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q        <= 2'b00;
      tx_clk_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], tx_clk};
      tx_clk_prev_q <= sync_q[1];
    end
  end

  assign nib_stb_c = sync_q[1] & ~tx_clk_prev_q;

  mii_crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (byte_q),
    .crc_o  (crc_next_c)
  );

  assign cnt_inc_c = cnt_q + LEN_W'(1);
  assign fcs_c     = ~crc_q;
  assign fcs_nib_c = fcs_c[{cnt_q[2:0], 2'b00} +: 4];

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      hi_q        <= 1'b0;
      byte_q      <= '0;
      crc_q       <= CRC_INIT;
      desc_wait_q <= 1'b0;
      rd_dly_q    <= 1'b0;
      tx_dv_q     <= 1'b0;
      tx_d_q      <= '0;
      ptr_rd_q    <= 1'b0;
      data_rd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      byte_q      <= byte_d;
      crc_q       <= crc_d;
      desc_wait_q <= desc_wait_d;
      rd_dly_q    <= rd_dly_d;
      tx_dv_q     <= tx_dv_d;
      tx_d_q      <= tx_d_d;
      ptr_rd_q    <= ptr_rd_d;
      data_rd_q   <= data_rd_d;
    end
  end

  // Next-state and output logic. IDLE/GETPTR run every clk; the frame
  // states advance only on a nibble strobe.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    hi_d        = hi_q;
    byte_d      = byte_q;
    crc_d       = crc_q;
    desc_wait_d = desc_wait_q;
    tx_dv_d     = tx_dv_q;
    tx_d_d      = tx_d_q;
    ptr_rd_d    = 1'b0;
    data_rd_d   = 1'b0;
    rd_dly_d    = data_rd_q;

    // FIFO dout is valid the clk after the read pulse; capture it then.
    if (rd_dly_q) begin
      byte_d = data_fifo_din;
    end

    unique case (state_q)
      ST_IDLE: begin
        crc_d = CRC_INIT;
        if (!ptr_fifo_empty) begin
          ptr_rd_d    = 1'b1;
          desc_wait_d = 1'b1;
          state_d     = ST_GETPTR;
        end
      end

      // First cycle: read pulse is on the bus. Second: descriptor is valid.
      ST_GETPTR: begin
        if (desc_wait_q) begin
          desc_wait_d = 1'b0;
        end else begin
          len_d   = ptr_fifo_din[LEN_W-1:0];
          cnt_d   = '0;
          hi_d    = 1'b0;
          state_d = (ptr_fifo_din[LEN_W-1:0] == '0) ? ST_IDLE : ST_PRE;
        end
      end

      // The SFD strobe also fetches the first data byte.
      ST_PRE: begin
        if (nib_stb_c) begin
          tx_dv_d = 1'b1;
          if (cnt_q == LEN_W'(PREAMBLE_NIBBLES)) begin
            tx_d_d    = SFD_NIBBLE;
            data_rd_d = 1'b1;
            cnt_d     = '0;
            hi_d      = 1'b0;
            state_d   = ST_DATA;
          end else begin
            tx_d_d = PREAMBLE_NIBBLE;
            cnt_d  = cnt_inc_c;
          end
        end
      end

      // DATA and PAD share the byte emitter; PAD just holds byte_q at zero.
      // cnt_q counts bytes sent so far across both states.
      ST_DATA, ST_PAD: begin
        if (nib_stb_c) begin
          tx_dv_d = 1'b1;
          if (!hi_q) begin
            tx_d_d = byte_q[3:0];
            hi_d   = 1'b1;
          end else begin
            tx_d_d = byte_q[7:4];
            hi_d   = 1'b0;
            crc_d  = crc_next_c;
            cnt_d  = cnt_inc_c;
            if (state_q == ST_DATA) begin
              if (cnt_inc_c != len_q) begin
                data_rd_d = 1'b1;
              end else if (len_q < LEN_W'(MIN_FRAME)) begin
                state_d = ST_PAD;
                byte_d  = '0;
              end else begin
                state_d = ST_FCS;
                cnt_d   = '0;
              end
            end else if (cnt_inc_c == LEN_W'(MIN_FRAME)) begin
              state_d = ST_FCS;
              cnt_d   = '0;
            end
          end
        end
      end

      ST_FCS: begin
        if (nib_stb_c) begin
          tx_dv_d = 1'b1;
          tx_d_d  = fcs_nib_c;
          if (cnt_q == LEN_W'(2 * FCS_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = ST_IFG;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end

      ST_IFG: begin
        if (nib_stb_c) begin
          tx_dv_d = 1'b0;
          tx_d_d  = '0;
          if (cnt_q == LEN_W'(IFG_NIBBLES - 1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign tx_dv        = tx_dv_q;
  assign tx_d         = tx_d_q;
  assign ptr_fifo_rd  = ptr_rd_q;
  assign data_fifo_rd = data_rd_q;

endmodule

// File: tb/tb_mii_mac_tx.sv
// Directed bench for mii_mac_tx with behavioural pointer/data FIFOs and a
// nibble-stream scoreboard.
module tb_mii_mac_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_clk = 1'b0;
  logic        tx_dv;
  logic [3:0]  tx_d;
  logic        data_fifo_rd;
  logic [7:0]  data_fifo_din;
  logic        ptr_fifo_rd;
  logic [15:0] ptr_fifo_din;
  logic        ptr_fifo_empty;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  dq[$];
  logic [15:0] pq[$];
  int          n_drd = 0;
  int          n_prd = 0;
  int          n_underrun = 0;

  logic [3:0]  rxn[$];
  int          rxl[$];
  int          gaps[$];
  int          cur_n = 0;
  int          gap_n = 0;
  bit          seen = 1'b0;

  logic [3:0]  expn[$];
  int          expl[$];

  always #5 clk = ~clk;
  always #20 tx_clk = ~tx_clk;

  mii_mac_tx dut (
    .clk            (clk),
    .rst            (rst),
    .tx_clk         (tx_clk),
    .tx_dv          (tx_dv),
    .tx_d           (tx_d),
    .data_fifo_rd   (data_fifo_rd),
    .data_fifo_din  (data_fifo_din),
    .ptr_fifo_rd    (ptr_fifo_rd),
    .ptr_fifo_din   (ptr_fifo_din),
    .ptr_fifo_empty (ptr_fifo_empty)
  );

  // Behavioural FIFOs: registered dout, cleared by the shared reset.
  initial begin
    data_fifo_din  = '0;
    ptr_fifo_din   = '0;
    ptr_fifo_empty = 1'b1;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        dq.delete();
        pq.delete();
        data_fifo_din  <= '0;
        ptr_fifo_din   <= '0;
        ptr_fifo_empty <= 1'b1;
      end else begin
        if (data_fifo_rd) begin
          n_drd++;
          if (dq.size() == 0) n_underrun++;
          else data_fifo_din <= dq.pop_front();
        end
        if (ptr_fifo_rd) begin
          n_prd++;
          if (pq.size() != 0) ptr_fifo_din <= pq.pop_front();
        end
        ptr_fifo_empty <= (pq.size() == 0);
      end
    end
  end

  // MII monitor: one sample per nibble time, away from clk edges.
  initial begin
    forever begin
      @(posedge tx_clk);
      if (rst) begin
        for (int i = 0; i < cur_n; i++) void'(rxn.pop_back());
        cur_n = 0;
      end else if (tx_dv) begin
        if (cur_n == 0 && seen) gaps.push_back(gap_n);
        rxn.push_back(tx_d);
        cur_n++;
      end else begin
        if (cur_n != 0) begin
          rxl.push_back(cur_n);
          cur_n = 0;
          seen  = 1'b1;
          gap_n = 0;
        end
        gap_n++;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h000000, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Push frame bytes + descriptor and the expected MII nibble stream.
  task automatic queue_frame(input int len);
    logic [7:0]  b;
    logic [31:0] c;
    int          tot;
    tot = (len < 60) ? 60 : len;
    c   = 32'hFFFFFFFF;
    for (int i = 0; i < 15; i++) expn.push_back(4'h5);
    expn.push_back(4'hD);
    for (int i = 0; i < tot; i++) begin
      b = (i < len) ? 8'($urandom) : 8'h00;
      if (i < len) dq.push_back(b);
      c = crc_byte(c, b);
      expn.push_back(b[3:0]);
      expn.push_back(b[7:4]);
    end
    c = ~c;
    for (int i = 0; i < 8; i++) expn.push_back(c[4*i +: 4]);
    expl.push_back(2 * (8 + tot + 4));
    pq.push_back({5'($urandom), 11'(len)});
  endtask

  task automatic queue_zero();
    pq.push_back({5'b10110, 11'd0});
  endtask

  task automatic drop_expected();
    int el;
    el = expl.pop_front();
    for (int i = 0; i < el; i++) void'(expn.pop_front());
  endtask

  // Wait for the next completed frame and compare it with the scoreboard.
  task automatic check_frame(input string tag);
    int          t;
    int          gl;
    int          el;
    int          n;
    int          mism;
    logic [3:0]  g;
    logic [3:0]  e;
    logic [7:0]  b;
    logic [31:0] c;
    t = 0;
    while (rxl.size() == 0 && t < 40000) begin
      @(negedge clk);
      t++;
    end
    if (rxl.size() == 0) begin
      chk({tag, "_arrived"}, 32'(rxl.size()), 32'd1);
      drop_expected();
      return;
    end
    gl   = rxl.pop_front();
    el   = expl.pop_front();
    n    = (gl > el) ? gl : el;
    mism = 0;
    c    = 32'hFFFFFFFF;
    b    = '0;
    chk({tag, "_nibbles"}, 32'(gl), 32'(el));
    for (int i = 0; i < n; i++) begin
      g = 4'h0;
      e = 4'h0;
      if (i < el) e = expn.pop_front();
      if (i < gl) begin
        g = rxn.pop_front();
        if (i >= 16) begin
          if (((i - 16) % 2) == 0) b[3:0] = g;
          else begin
            b[7:4] = g;
            c = crc_byte(c, b);
          end
        end
      end
      if (i >= gl || i >= el || g !== e) mism++;
    end
    chk({tag, "_stream_mismatches"}, 32'(mism), 32'd0);
    chk({tag, "_fcs_residue"}, c, 32'hDEBB20E3);
  endtask

  initial begin
    int d0;
    int p0;
    int lens[4];
    int mn;
    lens[0] = 100;
    lens[1] = 58;
    lens[2] = 60;
    lens[3] = 1514;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("rst_tx_d", 32'(tx_d), 32'd0);
    chk("rst_ptr_rd", 32'(ptr_fifo_rd), 32'd0);
    chk("rst_data_rd", 32'(data_fifo_rd), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_no_ptr_rd", 32'(n_prd), 32'd0);
    chk("idle_tx_dv", 32'(tx_dv), 32'd0);

    // Single frames.
    for (int k = 0; k < 4; k++) begin
      d0 = n_drd;
      p0 = n_prd;
      queue_frame(lens[k]);
      check_frame($sformatf("len%0d", lens[k]));
      chk($sformatf("len%0d_data_reads", lens[k]), 32'(n_drd - d0), 32'(lens[k]));
      chk($sformatf("len%0d_ptr_reads", lens[k]), 32'(n_prd - p0), 32'd1);
    end
    chk("single_dfifo_empty", 32'(dq.size()), 32'd0);
    chk("single_underrun", 32'(n_underrun), 32'd0);

    // Back-to-back descriptors, including a zero-length one.
    gaps.delete();
    d0 = n_drd;
    p0 = n_prd;
    queue_frame(100);
    queue_zero();
    queue_frame(58);
    queue_frame(60);
    queue_frame(1514);
    check_frame("b2b_100");
    check_frame("b2b_58");
    check_frame("b2b_60");
    check_frame("b2b_1514");
    repeat (20) @(negedge clk);
    chk("b2b_data_reads", 32'(n_drd - d0), 32'd1732);
    chk("b2b_ptr_reads", 32'(n_prd - p0), 32'd5);
    chk("b2b_dfifo_empty", 32'(dq.size()), 32'd0);
    chk("b2b_pfifo_empty", 32'(pq.size()), 32'd0);
    chk("b2b_underrun", 32'(n_underrun), 32'd0);
    chk("b2b_gap_count", 32'(gaps.size()), 32'd4);
    mn = 1000000;
    foreach (gaps[i]) if (gaps[i] < mn) mn = gaps[i];
    chk("b2b_min_gap_ge_24", 32'(mn >= 24), 32'd1);

    // Reset in the middle of DATA, then a clean frame.
    queue_frame(200);
    for (int t = 0; t < 20000 && cur_n < 60; t++) @(negedge clk);
    chk("pre_rst_tx_dv", 32'(tx_dv), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("mid_rst_tx_d", 32'(tx_d), 32'd0);
    drop_expected();
    repeat (12) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    d0 = n_drd;
    p0 = n_prd;
    queue_frame(64);
    check_frame("post_rst_64");
    chk("post_rst_data_reads", 32'(n_drd - d0), 32'd64);
    chk("post_rst_ptr_reads", 32'(n_prd - p0), 32'd1);
    chk("post_rst_underrun", 32'(n_underrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mii_mac_tx.md
# mii_mac_tx

MII transmit MAC for one switch egress port. Pops a frame descriptor from an external pointer FIFO (sfifo_w16_d32), pulls the frame bytes from an external data FIFO (sfifo_w8_d4k), and serialises the frame onto a 4-bit MII transmit bus. Each frame goes out as preamble/SFD, data, zero padding to the 60-byte minimum, and CRC-32 FCS, followed by a mandatory inter-frame gap. All logic runs on the single system clock; `tx_clk` is sampled as data.

## Interface
- No parameters. Constants live in the package.
- `clk` in 1: system clock. Must run at least 4× the `tx_clk` frequency (100 MHz vs 25 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `tx_clk` in 1: MII transmit clock from the PHY, sampled as data in the `clk` domain.
- `tx_dv` out 1: MII TX_EN.
- `tx_d` out 4: MII TXD nibble.
- `data_fifo_rd` out 1: one-cycle read pulse to the data FIFO.
- `data_fifo_din` in 8: data FIFO dout, valid 1 clk after `data_fifo_rd`.
- `ptr_fifo_rd` out 1: one-cycle read pulse to the pointer FIFO.
- `ptr_fifo_din` in 16: descriptor. [10:0] = frame length in bytes, excluding FCS. [15:11] reserved, ignored. Valid 1 clk after `ptr_fifo_rd`.
- `ptr_fifo_empty` in 1: pointer FIFO empty.

## Operation
- `tx_clk` passes through a 2-flop synchroniser. A rising-edge detect produces a one-`clk` `nib_stb`. All state advances and output updates occur only on `nib_stb`.
- FSM states and transitions:
  - IDLE -> GETPTR when `!ptr_fifo_empty`: pulse `ptr_fifo_rd`.
  - GETPTR: latch len = `ptr_fifo_din[10:0]` on the next clk.
    - len = 0: consume and discard, return to IDLE.
    - Otherwise go to PRE.
  - PRE: 15 nibbles 0x5, then 0xD (SFD), -> DATA.
  - DATA: len bytes, low nibble first.
  - PAD: 0x00 bytes until 60 bytes total have been sent. Skipped if len ≥ 60.
  - FCS: 4 bytes, low nibble first.
  - IFG: 24 nibble times with `tx_dv`=0.
  - After IFG, return to IDLE.
- Data fetch:
  - One `data_fifo_rd` pulse per data byte, issued in the clk of the `nib_stb` that emits the previous byte's high nibble (for the first byte, the SFD nibble).
  - Each byte is registered before its low nibble goes out.
  - Exactly len reads per frame. No reads in PAD, FCS or IFG.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Computed byte-wise over data+pad.
  - FCS = complement of the register, transmitted LSB first.
- No upper length check. Any len 1..2047 is transmitted as given.
- The FIFOs' own full/count handling stays in the writer's domain. This block never looks at FIFO depth.

## Timing
- Reset values:
  - `tx_dv`=0, `tx_d`=0, `ptr_fifo_rd`=0, `data_fifo_rd`=0.
  - FSM=IDLE, CRC=0xFFFFFFFF, synchroniser=0.
- `tx_dv`/`tx_d` change only in the clk after `nib_stb`. That is within 3 clk of the `tx_clk` rise, so they are stable before the next rise.
- `tx_dv` high for 2×(8 + max(len,60) + 4) consecutive nibbles:
  - len 100 -> 224 nibbles
  - len 58 -> 144
  - len 60 -> 144
  - len 1514 -> 3052
- Minimum gap from `tx_dv` fall to next rise: 24 nibbles.
- Back-to-back descriptors:
  - The next `ptr_fifo_rd` is issued in the first IDLE cycle.
  - No descriptor read happens while a frame or IFG is in progress.
- Reset mid-frame: outputs clear asynchronously and the frame is aborted. The FIFOs must be reset together with this block (same `rst` source).

## Structure
- Package `mii_mac_pkg` holds:
  - FSM state enum
  - PREAMBLE_NIBBLES=15, SFD_NIBBLE=4'hD
  - MIN_FRAME=60, FCS_BYTES=4, IFG_NIBBLES=24
  - CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3
- Sub-module `mii_crc32_d8`: combinational next-CRC for one byte.
- The data and pointer FIFOs are external and instantiated in the bench/top.

## Test plan
- Reset, then queue a 100-byte random frame -> 224 `tx_dv` nibbles:
  - 15×0x5, then 0xD.
  - 100 bytes matching FIFO contents, low nibble first.
  - CRC over data+FCS = 0xDEBB20E3.
  - Exactly 100 `data_fifo_rd` pulses and 1 `ptr_fifo_rd` pulse.
- 58-byte frame -> 2 zero pad bytes, 144 nibbles, 58 data reads, valid FCS.
- 60-byte frame -> no pad, 144 nibbles, 60 reads.
- 1514-byte frame -> 3052 nibbles, valid FCS, data FIFO empty afterwards.
- Queue all four frames back-to-back -> frames go out in order, each `tx_dv` gap ≥ 24 nibbles, no FIFO underrun or extra reads.
- Assert `rst` mid-DATA -> `tx_dv`=0 immediately. After release with the FIFOs also reset, the next queued frame transmits correctly.
